// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the hazard scoreboard slice.
package riscv_pipe_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CALL,
        ST_WAITDONE,
        ST_RELEASE
    } ecall_state_t;

endpackage

// File: rtl/hazard_scoreboard_cnt_bank.sv
// Bank of per-register pending-write counters. Register 0 is never tracked.
// Exposes zero/one/max flags per register and a sticky underflow/overflow error.
module sb_cnt_bank
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_en_i,
    input  logic [REG_IDX_W-1:0] inc_idx_i,
    input  logic                 dec_en_i,
    input  logic [REG_IDX_W-1:0] dec_idx_i,
    output logic [NREGS-1:0]     zero_o,
    output logic [NREGS-1:0]     one_o,
    output logic [NREGS-1:0]     max_o,
    output logic                 err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NREGS-1:0] X0_MASK = ~(NREGS'(1));

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic             err_q;
    logic             err_d;
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;

    // Decode inc/dec requests to one-hot, masking out x0
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc_en_i) inc_vec = (NREGS'(1) << inc_idx_i) & X0_MASK;
        if (dec_en_i) dec_vec = (NREGS'(1) << dec_idx_i) & X0_MASK;
    end

    // Next counter values; inc and dec on the same register cancel out
    always_comb begin
        err_d = err_q;
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // Counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Per-register status flags
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            zero_o[r] = (cnt_q[r] == '0);
            one_o[r]  = (cnt_q[r] == CNT_ONE);
            max_o[r]  = (cnt_q[r] == CNT_MAX);
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Central hazard controller: RAW/WAW stall generation from in-flight GPR
// writes, plus the ecall drain / handler handshake sequencer.
module hazard_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ID_valid,
    input  logic [REG_IDX_W-1:0] ID_rs1,
    input  logic [REG_IDX_W-1:0] ID_rs2,
    input  logic                 ID_use_rs1,
    input  logic                 ID_use_rs2,
    input  logic [REG_IDX_W-1:0] ID_rd,
    input  logic                 ID_wr_rd,
    input  logic                 ID_ecall,
    input  logic                 EXID_stall,
    input  logic                 EXIF_branch,
    input  logic                 WB_valid,
    input  logic [REG_IDX_W-1:0] WB_rd,
    input  logic                 ecalldone,
    output logic                 IDIF_stall,
    output logic                 IDEX_issue,
    output logic                 ecall_start,
    output logic                 ecall_busy,
    output logic                 sb_empty,
    output logic                 sb_err
);

    ecall_state_t     state_q;
    logic             ecall_start_q;
    logic             ecall_busy_q;

    logic [NREGS-1:0] zero_vec;
    logic [NREGS-1:0] one_vec;
    logic [NREGS-1:0] max_vec;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             inc_en;
    logic             dec_en;

    sb_cnt_bank #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_cnt_bank (
        .clk       (clk),
        .rst_n     (reset),
        .inc_en_i  (inc_en),
        .inc_idx_i (ID_rd),
        .dec_en_i  (dec_en),
        .dec_idx_i (WB_rd),
        .zero_o    (zero_vec),
        .one_o     (one_vec),
        .max_o     (max_vec),
        .err_o     (sb_err)
    );

    // Hazard detection; a writeback retiring the last pending write bypasses via the regfile
    always_comb begin
        raw1 = ID_use_rs1 && (ID_rs1 != '0) && !zero_vec[ID_rs1]
            && !(WB_valid && (WB_rd == ID_rs1) && one_vec[ID_rs1]);
        raw2 = ID_use_rs2 && (ID_rs2 != '0) && !zero_vec[ID_rs2]
            && !(WB_valid && (WB_rd == ID_rs2) && one_vec[ID_rs2]);
        waw  = ID_wr_rd && (ID_rd != '0) && max_vec[ID_rd];
    end

    // Stall / issue decision and counter update requests
    always_comb begin
        IDIF_stall = EXID_stall
                  || (ID_valid && (raw1 || raw2 || waw))
                  || (state_q != ST_IDLE)
                  || (ID_valid && ID_ecall);
        IDEX_issue = ID_valid && !IDIF_stall && !EXIF_branch;
        inc_en     = IDEX_issue && ID_wr_rd && (ID_rd != '0);
        dec_en     = WB_valid && (WB_rd != '0);
        sb_empty   = &zero_vec;
    end

    // Ecall sequencer with registered start pulse and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ecall_start_q <= 1'b0;
            ecall_busy_q  <= 1'b0;
        end else begin
            ecall_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ID_valid && ID_ecall && !EXIF_branch && !EXID_stall) begin
                        state_q      <= ST_DRAIN;
                        ecall_busy_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // A taken branch here means the ecall was wrong-path: abandon it
                    if (EXIF_branch) begin
                        state_q      <= ST_IDLE;
                        ecall_busy_q <= 1'b0;
                    end else if (sb_empty) begin
                        state_q       <= ST_CALL;
                        ecall_start_q <= 1'b1;
                    end
                end
                ST_CALL: begin
                    state_q <= ST_WAITDONE;
                end
                ST_WAITDONE: begin
                    if (ecalldone) state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    state_q      <= ST_IDLE;
                    ecall_busy_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    ecall_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign ecall_start = ecall_start_q;
    assign ecall_busy  = ecall_busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       ID_valid;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_use_rs1;
    logic       ID_use_rs2;
    logic [4:0] ID_rd;
    logic       ID_wr_rd;
    logic       ID_ecall;
    logic       EXID_stall;
    logic       EXIF_branch;
    logic       WB_valid;
    logic [4:0] WB_rd;
    logic       ecalldone;
    logic       IDIF_stall;
    logic       IDEX_issue;
    logic       ecall_start;
    logic       ecall_busy;
    logic       sb_empty;
    logic       sb_err;

    int unsigned n_checks;
    int unsigned n_fails;

    hazard_scoreboard #(
        .NREGS (32),
        .CNT_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ID_valid    (ID_valid),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_use_rs1  (ID_use_rs1),
        .ID_use_rs2  (ID_use_rs2),
        .ID_rd       (ID_rd),
        .ID_wr_rd    (ID_wr_rd),
        .ID_ecall    (ID_ecall),
        .EXID_stall  (EXID_stall),
        .EXIF_branch (EXIF_branch),
        .WB_valid    (WB_valid),
        .WB_rd       (WB_rd),
        .ecalldone   (ecalldone),
        .IDIF_stall  (IDIF_stall),
        .IDEX_issue  (IDEX_issue),
        .ecall_start (ecall_start),
        .ecall_busy  (ecall_busy),
        .sb_empty    (sb_empty),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        ID_valid    = 1'b0;
        ID_rs1      = '0;
        ID_rs2      = '0;
        ID_use_rs1  = 1'b0;
        ID_use_rs2  = 1'b0;
        ID_rd       = '0;
        ID_wr_rd    = 1'b0;
        ID_ecall    = 1'b0;
        EXID_stall  = 1'b0;
        EXIF_branch = 1'b0;
        WB_valid    = 1'b0;
        WB_rd       = '0;
        ecalldone   = 1'b0;
    endtask

    task automatic present_wr(input logic [4:0] rd);
        idle();
        ID_valid = 1'b1;
        ID_wr_rd = 1'b1;
        ID_rd    = rd;
    endtask

    task automatic present_ecall();
        idle();
        ID_valid = 1'b1;
        ID_ecall = 1'b1;
    endtask

    task automatic wb(input logic [4:0] rd);
        WB_valid = 1'b1;
        WB_rd    = rd;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        idle();

        // Reset state
        #3;
        check("rst_stall", IDIF_stall, 1'b0);
        check("rst_empty", sb_empty, 1'b1);
        check("rst_start", ecall_start, 1'b0);
        check("rst_busy", ecall_busy, 1'b0);
        check("rst_err", sb_err, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // 1: RAW on x5, released same cycle by WB bypass
        present_wr(5'd5);
        settle();
        check("t1_issue_addi", IDEX_issue, 1'b1);
        tick();
        present_wr(5'd6);
        ID_use_rs1 = 1'b1; ID_rs1 = 5'd5;
        ID_use_rs2 = 1'b1; ID_rs2 = 5'd1;
        settle();
        check("t1_raw_stall", IDIF_stall, 1'b1);
        check("t1_raw_noissue", IDEX_issue, 1'b0);
        check("t1_not_empty", sb_empty, 1'b0);
        tick();
        check("t1_still_stall", IDIF_stall, 1'b1);
        wb(5'd5);
        settle();
        check("t1_bypass_stall", IDIF_stall, 1'b0);
        check("t1_bypass_issue", IDEX_issue, 1'b1);
        tick();
        idle();
        wb(5'd6);
        tick();
        idle();
        settle();
        check("t1_empty", sb_empty, 1'b1);

        // 2: WAW at counter max on x7
        for (int i = 0; i < 3; i++) begin
            present_wr(5'd7);
            settle();
            check("t2_issue_x7", IDEX_issue, 1'b1);
            tick();
        end
        present_wr(5'd7);
        settle();
        check("t2_waw_stall", IDIF_stall, 1'b1);
        tick();
        wb(5'd7);
        settle();
        check("t2_waw_wb_cycle", IDIF_stall, 1'b1);
        tick();
        WB_valid = 1'b0;
        settle();
        check("t2_waw_release", IDIF_stall, 1'b0);
        check("t2_waw_issue", IDEX_issue, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            wb(5'd7);
            tick();
        end
        idle();
        settle();
        check("t2_empty", sb_empty, 1'b1);
        check("t2_err", sb_err, 1'b0);

        // 3: same-cycle inc/dec on x9 leaves count at 1
        present_wr(5'd9);
        tick();
        present_wr(5'd9);
        wb(5'd9);
        settle();
        check("t3_issue", IDEX_issue, 1'b1);
        tick();
        idle();
        settle();
        check("t3_not_empty", sb_empty, 1'b0);
        check("t3_err", sb_err, 1'b0);
        wb(5'd9);
        tick();
        idle();
        settle();
        check("t3_empty_after_wb", sb_empty, 1'b1);
        check("t3_err_after_wb", sb_err, 1'b0);

        // 4: full ecall sequence with two pending writes
        present_wr(5'd10);
        tick();
        present_wr(5'd11);
        tick();
        present_ecall();
        settle();
        check("t4_ecall_stall", IDIF_stall, 1'b1);
        check("t4_ecall_noissue", IDEX_issue, 1'b0);
        check("t4_busy_pre", ecall_busy, 1'b0);
        tick();
        settle();
        check("t4_drain_busy", ecall_busy, 1'b1);
        check("t4_drain_start0", ecall_start, 1'b0);
        tick();
        wb(5'd10);
        settle();
        check("t4_drain2_start0", ecall_start, 1'b0);
        tick();
        wb(5'd11);
        settle();
        check("t4_drain3_start0", ecall_start, 1'b0);
        tick();
        WB_valid = 1'b0;
        settle();
        check("t4_drain4_start0", ecall_start, 1'b0);
        check("t4_drain4_empty", sb_empty, 1'b1);
        tick();
        ecalldone = 1'b1;
        settle();
        check("t4_call_start", ecall_start, 1'b1);
        check("t4_call_stall", IDIF_stall, 1'b1);
        tick();
        ecalldone = 1'b0;
        settle();
        check("t4_wait_start0", ecall_start, 1'b0);
        check("t4_wait_busy", ecall_busy, 1'b1);
        tick();
        settle();
        check("t4_wait2_stall", IDIF_stall, 1'b1);
        check("t4_wait2_busy", ecall_busy, 1'b1);
        ecalldone = 1'b1;
        tick();
        // decode now holds the NOP substituted for the ecall
        present_wr(5'd0);
        settle();
        check("t4_release_stall", IDIF_stall, 1'b1);
        check("t4_release_busy", ecall_busy, 1'b1);
        tick();
        settle();
        check("t4_idle_busy", ecall_busy, 1'b0);
        check("t4_idle_stall", IDIF_stall, 1'b0);
        check("t4_idle_issue", IDEX_issue, 1'b1);
        check("t4_nop_no_count", sb_empty, 1'b1);
        tick();

        // 5: ecall abandoned by branch while draining
        present_wr(5'd12);
        tick();
        present_ecall();
        tick();
        EXIF_branch = 1'b1;
        settle();
        check("t5_drain_busy", ecall_busy, 1'b1);
        tick();
        idle();
        settle();
        check("t5_idle_busy", ecall_busy, 1'b0);
        check("t5_idle_stall", IDIF_stall, 1'b0);
        check("t5_start0", ecall_start, 1'b0);
        wb(5'd12);
        tick();
        idle();
        settle();
        check("t5_start0_late", ecall_start, 1'b0);
        check("t5_empty", sb_empty, 1'b1);

        // 6: sticky underflow error, then reset during WAITDONE
        wb(5'd3);
        tick();
        idle();
        settle();
        check("t6_err_set", sb_err, 1'b1);
        tick();
        settle();
        check("t6_err_sticky", sb_err, 1'b1);
        present_ecall();
        tick();
        tick();
        settle();
        check("t6_call_start", ecall_start, 1'b1);
        tick();
        settle();
        check("t6_wait_busy", ecall_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_rst_busy", ecall_busy, 1'b0);
        check("t6_rst_start", ecall_start, 1'b0);
        check("t6_rst_err", sb_err, 1'b0);
        check("t6_rst_empty", sb_empty, 1'b1);
        idle();
        #1;
        check("t6_rst_stall", IDIF_stall, 1'b0);
        tick();
        settle();
        check("t6_rst_start_hold", ecall_start, 1'b0);
        reset = 1'b1;
        tick();
        settle();
        check("t6_post_busy", ecall_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
